// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes, shift-add MUL and restoring UDIV/SDIV.
// Optional build macro ALU_SEQ_FAST_MUL_EN turns MUL into a single-cycle combinational multiply.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic             div_by_zero
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORR  = 3'b011,
    OP_MUL  = 3'b100,
    OP_UDIV = 3'b101,
    OP_SDIV = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

`ifdef ALU_SEQ_FAST_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_busy_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;     // product accumulator (MUL) or partial remainder (DIV)
  logic [WIDTH-1:0] r_opa;     // multiplicand (MUL) or dividend shifting into quotient (DIV)
  logic [WIDTH-1:0] r_opb;     // multiplier (MUL) or divisor (DIV)
  logic             r_neg;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;
  logic             r_dbz;

  op_t              w_op;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_last;
  logic             w_in_mul;

  assign w_op = op_t'(alu_control);

  // ---------------------------------------------------------------- single-step datapath
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_ss_res;
  logic             w_ss_c;
  logic             w_ss_v;
  logic             w_ss_dbz;
  logic             w_ss_multi;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign w_abs_a = a[WIDTH-1] ? -a : a;
  assign w_abs_b = b[WIDTH-1] ? -b : b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_ss_res   = '0;
    w_ss_c     = 1'b0;
    w_ss_v     = 1'b0;
    w_ss_dbz   = 1'b0;
    w_ss_multi = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_ss_res = w_add[WIDTH-1:0];
        w_ss_c   = w_add[WIDTH];
        w_ss_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_ss_res = w_sub[WIDTH-1:0];
        w_ss_c   = w_sub[WIDTH];
        w_ss_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_ss_res = a & b;
      OP_ORR: w_ss_res = a | b;
`ifdef ALU_SEQ_FAST_MUL_EN
      OP_MUL: w_ss_res = a * b;
`else
      OP_MUL: w_ss_multi = 1'b1;
`endif
      OP_UDIV, OP_SDIV: begin
        if (b == '0) w_ss_dbz = 1'b1;
        else         w_ss_multi = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- iterative datapath
  logic [WIDTH:0]   w_rem_sh;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_div_res;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_fin_res;

  // The remainder never exceeds the divisor, so the low WIDTH bits of the difference are exact.
  assign w_rem_sh   = {r_acc, r_opa[WIDTH-1]};
  assign w_qbit     = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_next = w_qbit ? (w_rem_sh[WIDTH-1:0] - r_opb) : w_rem_sh[WIDTH-1:0];
  assign w_quo_next = {r_opa[WIDTH-2:0], w_qbit};
  assign w_div_res  = r_neg ? -w_quo_next : w_quo_next;
  assign w_mul_acc  = r_opb[0] ? (r_acc + r_opa) : r_acc;
  assign w_fin_res  = w_in_mul ? w_mul_acc : w_div_res;
  assign w_last     = (r_cnt == CNT_LAST);

`ifdef ALU_SEQ_FAST_MUL_EN
  assign w_in_mul     = 1'b0;
  assign w_busy_state = S_DIV;
`else
  assign w_in_mul     = (r_state == S_MUL);
  assign w_busy_state = (w_op == OP_MUL) ? S_MUL : S_DIV;
`endif

  // ---------------------------------------------------------------- control FSM
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: w_in_ready = 1'b1;
      S_DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
    endcase
    if (in_valid && w_in_ready) w_state_next = w_ss_multi ? w_busy_state : S_DONE;
  end

  assign w_accept  = in_valid && w_in_ready;
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_flags  <= 4'b0000;
      r_dbz    <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_neg <= (w_op == OP_SDIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
      if (w_op == OP_SDIV) begin
        r_opa <= w_abs_a;
        r_opb <= w_abs_b;
      end else begin
        r_opa <= a;
        r_opb <= b;
      end
      if (!w_ss_multi) begin
        r_result <= w_ss_res;
        r_flags  <= {w_ss_res[WIDTH-1], (w_ss_res == '0), w_ss_c, w_ss_v};
        r_dbz    <= w_ss_dbz;
      end
    end else if (w_busy) begin
      if (w_in_mul) begin
        r_acc <= w_mul_acc;
        r_opa <= r_opa << 1;
        r_opb <= r_opb >> 1;
      end else begin
        r_acc <= w_rem_next;
        r_opa <= w_quo_next;
      end
      // The last iteration registers the sign-fixed result directly, saving a separate cycle.
      if (w_last) begin
        r_result <= w_fin_res;
        r_flags  <= {w_fin_res[WIDTH-1], (w_fin_res == '0), 2'b00};
        r_dbz    <= 1'b0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign result      = r_result;
  assign alu_flags   = r_flags;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed handshake scenarios plus randomized ops against
// an arithmetic reference model.
module tb_alu_seq;

  localparam int W       = 32;
  localparam int DIV_LAT = W + 1;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));

  logic         clk         = 1'b0;
  logic         rst_n       = 1'b0;
  logic         in_valid    = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_control = 3'b000;
  logic [W-1:0] a           = '0;
  logic [W-1:0] b           = '0;
  logic         out_valid;
  logic         out_ready   = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   alu_flags;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .alu_flags  (alu_flags),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         dbz;
  } exp_t;

  // Reference model: plain 64-bit arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t            e;
    longint          sx, sy, t;
    longint unsigned ux, uy, u;
    logic            c, v;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    c = 1'b0; v = 1'b0;
    e.res = '0; e.dbz = 1'b0;
    case (op)
      3'd0: begin
        u = ux + uy; e.res = u[W-1:0]; c = u[W];
        t = sx + sy; v = (t > SMAX) || (t < SMIN);
      end
      3'd1: begin
        e.res = x - y; c = (x >= y);
        t = sx - sy; v = (t > SMAX) || (t < SMIN);
      end
      3'd2: e.res = x & y;
      3'd3: e.res = x | y;
      3'd4: begin u = ux * uy; e.res = u[W-1:0]; end
      3'd5: if (y == '0) e.dbz = 1'b1; else e.res = x / y;
      3'd6: if (y == '0) e.dbz = 1'b1; else begin t = sx / sy; e.res = t[W-1:0]; end
      default: ;
    endcase
    e.flags = {e.res[W-1], (e.res == '0), c, v};
    return e;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] y);
    if (op == 3'd4) return MUL_LAT;
    if ((op == 3'd5 || op == 3'd6) && y != '0) return DIV_LAT;
    return 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return {{(W-1){1'b0}}, 1'b1};
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check({tag, " result"}, 64'(result), 64'(e.res));
    check({tag, " flags"}, 64'(alu_flags), 64'(e.flags));
    check({tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
  endtask

  // Issue one op from IDLE, measure latency, check outputs, then drain back to IDLE.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   lat;
    int   busy_ready;
    e = model(op, x, y);
    @(negedge clk);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'(1'b1));
    in_valid = 1'b1; alu_control = op; a = x; b = y; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; alu_control = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1; busy_ready = 0;
    @(negedge clk);
    while (!out_valid && lat < 4 * W) begin
      if (in_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat(op, y)));
    check({tag, " in_ready while busy"}, 64'(busy_ready), 64'(0));
    check_out(tag, e);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " drained"}, 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    exp_t         e;
    exp_t         q[$];
    int           waited;
    logic [2:0]   op;
    logic [W-1:0] x, y;

    // Reset values
    #12;
    check("reset in_ready", 64'(in_ready), 64'(1'b1));
    check("reset out_valid", 64'(out_valid), 64'(1'b0));
    check("reset result", 64'(result), 64'(0));
    check("reset flags", 64'(alu_flags), 64'(0));
    check("reset dbz", 64'(div_by_zero), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // ADD/SUB carry and overflow
    do_op("add ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add ovf literal", 64'({result, alu_flags}), 64'({32'h8000_0000, 4'b1001}));
    do_op("sub neg", 3'd1, 32'd3, 32'd5);
    check("sub neg literal", 64'({result, alu_flags}), 64'({32'hFFFF_FFFE, 4'b1000}));

    // MUL and divisions
    do_op("mul", 3'd4, 32'h0001_2345, 32'h0000_0100);
    check("mul literal", 64'(result), 64'(32'h0123_4500));
    do_op("udiv", 3'd5, 32'd100, 32'd7);
    check("udiv literal", 64'(result), 64'(32'd14));
    do_op("sdiv neg", 3'd6, 32'hFFFF_FF9C, 32'd7);
    check("sdiv neg literal", 64'(result), 64'(32'hFFFF_FFF2));
    do_op("sdiv minneg", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    check("sdiv minneg literal", 64'({result, alu_flags}), 64'({32'h8000_0000, 4'b1000}));
    do_op("udiv by zero", 3'd5, 32'd5, 32'd0);
    do_op("sdiv by zero", 3'd6, 32'hFFFF_FFF0, 32'd0);
    do_op("reserved", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);

    // Back-pressure: a held in_valid must wait through DIV and the stalled DONE
    e = model(3'd5, 32'hFFFF_0000, 32'd3);
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'd5; a = 32'hFFFF_0000; b = 32'd3;
    @(posedge clk);
    #1;
    alu_control = 3'd3; a = 32'h0000_00F0; b = 32'h0000_000F;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 4 * W) begin
      @(negedge clk);
      waited++;
    end
    check("bp div latency", 64'(waited + 1), 64'(DIV_LAT));
    for (int i = 0; i < 10; i++) begin
      check("bp hold valid", 64'(out_valid), 64'(1'b1));
      check("bp hold in_ready", 64'(in_ready), 64'(1'b0));
      check_out("bp hold", e);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp handover in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("bp next valid", 64'(out_valid), 64'(1'b1));
    check_out("bp next", model(3'd3, 32'h0000_00F0, 32'h0000_000F));
    check("bp next literal", 64'(result), 64'(32'h0000_00FF));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Back-to-back single-step ADDs, one result per cycle
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; alu_control = 3'd0;
    for (int i = 0; i < 8; i++) begin
      x = pick(); y = pick();
      a = x; b = y;
      q.push_back(model(3'd0, x, y));
      check("b2b in_ready", 64'(in_ready), 64'(1'b1));
      @(posedge clk);
      @(negedge clk);
      e = q.pop_front();
      check("b2b valid", 64'(out_valid), 64'(1'b1));
      check_out("b2b", e);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("b2b drained", 64'(out_valid), 64'(1'b0));

    // Randomized ops from IDLE
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      x = pick(); y = pick();
      do_op("rand", op, x, y);
    end

    // Reset during DIV iteration 15
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'd5; a = 32'hDEAD_BEEF; b = 32'h0000_0123;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midop rst out_valid", 64'(out_valid), 64'(1'b0));
    check("midop rst in_ready", 64'(in_ready), 64'(1'b1));
    check("midop rst result", 64'(result), 64'(0));
    check("midop rst flags", 64'(alu_flags), 64'(0));
    check("midop rst dbz", 64'(div_by_zero), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post rst add", 3'd0, 32'd2, 32'd2);
    check("post rst literal", 64'(result), 64'(32'd4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
